// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU state encoding
// and the request legality check applied at accept time.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    LD_CAP   = 3'd2,
    ST_MERGE = 3'd3,
    WR       = 3'd4
  } lsu_state_t;

  // True when funct3 is legal for the direction and the address is naturally aligned.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering between the big-endian memory port and little-endian core:
// load extract/extend and store swizzle/read-modify-write merge.
module lsu_byte_lane
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;
  logic [31:0] st_swap;

  // mem[A] arrives in rdata[31:24], so the lowest-addressed byte is the LSB.
  always_comb begin
    ld_byte = rdata[31:24];
    ld_half = {rdata[23:16], rdata[31:24]};
    ld_word = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
    st_swap = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
  end

  always_comb begin
    load_data  = '0;
    store_word = '0;
    case (funct3)
      F3_B: begin
        load_data  = {{24{ld_byte[7]}}, ld_byte};
        store_word = {st_swap[31:24], rdata[23:0]};
      end
      F3_H: begin
        load_data  = {{16{ld_half[15]}}, ld_half};
        store_word = {st_swap[31:16], rdata[15:0]};
      end
      F3_W: begin
        load_data  = ld_word;
        store_word = st_swap;
      end
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_HU:   load_data = {16'd0, ld_half};
      default: begin
        load_data  = '0;
        store_word = '0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, drives a big-endian word-wide
// data memory with registered strobes and read-modify-write for SB/SH.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_store,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_t    state, state_next;
  logic          accept;
  logic          req_ok;
  logic          op_is_store;
  logic [2:0]    op_funct3;
  logic [DW-1:0] op_wdata;
  logic [2:0]    lane_funct3;
  logic [DW-1:0] lane_wdata;
  logic [DW-1:0] lane_load;
  logic [DW-1:0] lane_store;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_ok    = access_ok(req_is_store, req_funct3, req_addr[1:0]);

  // In IDLE the lane swizzles the incoming SW data; later it works on the latched op.
  assign lane_funct3 = (state == IDLE) ? req_funct3 : op_funct3;
  assign lane_wdata  = (state == IDLE) ? req_wdata  : op_wdata;

  lsu_byte_lane u_lane (
    .funct3     (lane_funct3),
    .rdata      (mem_rdata),
    .wdata      (lane_wdata),
    .load_data  (lane_load),
    .store_word (lane_store)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && req_ok)
          state_next = (req_is_store && req_funct3 == F3_W) ? WR : RD;
      end
      RD:       state_next = op_is_store ? ST_MERGE : LD_CAP;
      LD_CAP:   state_next = IDLE;
      ST_MERGE: state_next = WR;
      WR:       state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Strobes follow the next state so they are registered yet aligned with RD/WR.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      op_is_store <= 1'b0;
      op_funct3   <= '0;
      op_wdata    <= '0;
    end else begin
      mem_read   <= (state_next == RD);
      mem_write  <= (state_next == WR);
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (state == IDLE && accept) begin
        if (req_ok) begin
          mem_address <= req_addr;
          op_is_store <= req_is_store;
          op_funct3   <= req_funct3;
          op_wdata    <= req_wdata;
          if (state_next == WR) mem_wdata <= lane_store;
        end else begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
      end
      if (state == ST_MERGE) mem_wdata <= lane_store;
      if (state == LD_CAP) begin
        resp_valid <= 1'b1;
        resp_rdata <= lane_load;
      end
      if (state == WR) resp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 256-byte big-endian memory model
// with a one-cycle registered read port.
module tb_load_store_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  int          rd_count = 0;
  int          wr_count = 0;
  int          n_checked = 0;
  int          n_failed = 0;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign ma = mem_address[7:0];

  // Memory: mem[A] sits in bits [31:24]; reads are registered.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};
      rd_count  <= rd_count + 1;
    end
    if (mem_write) begin
      mem[ma]        <= mem_wdata[31:24];
      mem[ma + 8'd1] <= mem_wdata[23:16];
      mem[ma + 8'd2] <= mem_wdata[15:8];
      mem[ma + 8'd3] <= mem_wdata[7:0];
      wr_count       <= wr_count + 1;
    end
  end

  // Issues one request and waits (bounded) for its response; lat counts edges from accept.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int nrd, output int nwr);
    int r0, w0;
    r0 = rd_count;
    w0 = wr_count;
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = resp_rdata;
    er  = resp_err;
    nrd = rd_count - r0;
    nwr = wr_count - w0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checked++;
    if (req_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
    n_checked++;
    if ({mem_read, mem_write, resp_valid, resp_err} !== 4'b0000) begin
      n_failed++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, resp_valid, resp_err});
    end
    n_checked++;
    if (mem_address !== 32'd0 || mem_wdata !== 32'd0 || resp_rdata !== 32'd0) begin
      n_failed++; $display("[TB] FAIL reset_data: got addr %h wdata %h rdata %h expected all 0", mem_address, mem_wdata, resp_rdata);
    end
  endtask

  task automatic test_store_word();
    int lat, nrd, nwr; logic [31:0] rd; logic er;
    do_req(1'b1, F3_W, 32'h10, 32'h11223344, lat, rd, er, nrd, nwr);
    n_checked++;
    if (lat !== 2) begin n_failed++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
    n_checked++;
    if (rd !== 32'd0 || er !== 1'b0) begin n_failed++; $display("[TB] FAIL sw_resp: got rdata %h err %b expected 0/0", rd, er); end
    n_checked++;
    if (nrd !== 0 || nwr !== 1) begin n_failed++; $display("[TB] FAIL sw_mem_ops: got rd %0d wr %0d expected 0/1", nrd, nwr); end
    n_checked++;
    if (mem[8'h10] !== 8'h44 || mem[8'h13] !== 8'h11) begin
      n_failed++; $display("[TB] FAIL sw_bytes: got [10]=%h [13]=%h expected 44/11", mem[8'h10], mem[8'h13]);
    end
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (lat !== 3) begin n_failed++; $display("[TB] FAIL lw_latency: got %0d expected 3", lat); end
    n_checked++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin n_failed++; $display("[TB] FAIL lw_data: got %h err %b expected 11223344", rd, er); end
  endtask

  task automatic test_store_byte();
    int lat, nrd, nwr; logic [31:0] rd; logic er;
    do_req(1'b1, F3_B, 32'h11, 32'h000000AB, lat, rd, er, nrd, nwr);
    n_checked++;
    if (lat !== 4) begin n_failed++; $display("[TB] FAIL sb_latency: got %0d expected 4", lat); end
    n_checked++;
    if (nrd !== 1 || nwr !== 1) begin n_failed++; $display("[TB] FAIL sb_mem_ops: got rd %0d wr %0d expected 1/1", nrd, nwr); end
    n_checked++;
    if (rd !== 32'd0 || er !== 1'b0) begin n_failed++; $display("[TB] FAIL sb_resp: got rdata %h err %b expected 0/0", rd, er); end
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'h1122AB44) begin n_failed++; $display("[TB] FAIL sb_lw: got %h expected 1122ab44", rd); end
    do_req(1'b0, F3_B, 32'h11, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'hFFFFFFAB) begin n_failed++; $display("[TB] FAIL lb: got %h expected ffffffab", rd); end
    do_req(1'b0, F3_BU, 32'h11, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'h000000AB) begin n_failed++; $display("[TB] FAIL lbu: got %h expected 000000ab", rd); end
  endtask

  task automatic test_store_half();
    int lat, nrd, nwr; logic [31:0] rd; logic er;
    do_req(1'b1, F3_H, 32'h12, 32'h00008001, lat, rd, er, nrd, nwr);
    n_checked++;
    if (lat !== 4 || nrd !== 1 || nwr !== 1) begin
      n_failed++; $display("[TB] FAIL sh_timing: got lat %0d rd %0d wr %0d expected 4/1/1", lat, nrd, nwr);
    end
    do_req(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'h8001AB44) begin n_failed++; $display("[TB] FAIL sh_lw: got %h expected 8001ab44", rd); end
    do_req(1'b0, F3_H, 32'h12, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'hFFFF8001) begin n_failed++; $display("[TB] FAIL lh: got %h expected ffff8001", rd); end
    do_req(1'b0, F3_HU, 32'h12, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'h00008001) begin n_failed++; $display("[TB] FAIL lhu: got %h expected 00008001", rd); end
  endtask

  task automatic test_errors();
    int lat, nrd, nwr; logic [31:0] rd; logic er;
    logic st; logic [2:0] f3; logic [31:0] a;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       begin st = 1'b0; f3 = F3_W;   a = 32'h13; end
        1:       begin st = 1'b1; f3 = F3_H;   a = 32'h11; end
        2:       begin st = 1'b0; f3 = 3'b011; a = 32'h10; end
        3:       begin st = 1'b1; f3 = F3_BU;  a = 32'h10; end
        default: begin st = 1'b0; f3 = F3_HU;  a = 32'h21; end
      endcase
      do_req(st, f3, a, 32'hCAFEF00D, lat, rd, er, nrd, nwr);
      n_checked++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nrd !== 0 || nwr !== 0) begin
        n_failed++;
        $display("[TB] FAIL err_case%0d: got lat %0d err %b rdata %h rd %0d wr %0d expected 1/1/0/0/0",
                 i, lat, er, rd, nrd, nwr);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, nrd, nwr, w0; logic [31:0] rd; logic er; logic seen;
    do_req(1'b1, F3_W, 32'h20, 32'hDEADBEEF, lat, rd, er, nrd, nwr);
    w0 = wr_count;
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h20; req_wdata = 32'h000000FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checked++;
    if (mem_read !== 1'b1 || req_ready !== 1'b0) begin
      n_failed++; $display("[TB] FAIL sb_rd_phase: got read %b ready %b expected 1/0", mem_read, req_ready);
    end
    @(posedge clk); #1;
    seen = resp_valid;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checked++;
    if (req_ready !== 1'b1 || mem_write !== 1'b0) begin
      n_failed++; $display("[TB] FAIL midrst_state: got ready %b write %b expected 1/0", req_ready, mem_write);
    end
    repeat (4) begin
      seen = seen | resp_valid;
      @(posedge clk); #1;
    end
    n_checked++;
    if (seen !== 1'b0 || (wr_count - w0) !== 0) begin
      n_failed++; $display("[TB] FAIL midrst_quiet: got resp %b writes %0d expected 0/0", seen, wr_count - w0);
    end
    do_req(1'b0, F3_W, 32'h20, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'hDEADBEEF) begin n_failed++; $display("[TB] FAIL midrst_lw: got %h expected deadbeef", rd); end
    do_req(1'b0, F3_B, 32'h20, 32'h0, lat, rd, er, nrd, nwr);
    n_checked++;
    if (rd !== 32'hFFFFFFEF) begin n_failed++; $display("[TB] FAIL midrst_lb: got %h expected ffffffef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp_data [4];
    int acc_cyc [4];
    int rsp_cyc [4];
    int n_acc, n_rsp, cyc;
    logic rdy;
    addrs    = '{32'h10, 32'h20, 32'h10, 32'h20};
    exp_data = '{32'h8001AB44, 32'hDEADBEEF, 32'h8001AB44, 32'hDEADBEEF};
    acc_cyc  = '{0, 0, 0, 0};
    rsp_cyc  = '{0, 0, 0, 0};
    n_acc = 0; n_rsp = 0; cyc = 0;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = F3_W;
    req_addr = addrs[0]; req_wdata = 32'd0;
    while (n_rsp < 4 && cyc < 60) begin
      rdy = req_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy && req_valid) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 4) req_addr = addrs[n_acc];
        else           req_valid = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        rsp_cyc[n_rsp] = cyc;
        n_checked++;
        if (resp_rdata !== exp_data[n_rsp] || resp_err !== 1'b0) begin
          n_failed++; $display("[TB] FAIL b2b_data%0d: got %h err %b expected %h", n_rsp, resp_rdata, resp_err, exp_data[n_rsp]);
        end
        n_rsp++;
      end
    end
    req_valid = 1'b0;
    n_checked++;
    if (n_rsp !== 4) begin n_failed++; $display("[TB] FAIL b2b_count: got %0d responses expected 4", n_rsp); end
    for (int j = 0; j < 3; j++) begin
      n_checked++;
      if (acc_cyc[j+1] !== rsp_cyc[j] + 1 || rsp_cyc[j+1] - rsp_cyc[j] !== 3) begin
        n_failed++;
        $display("[TB] FAIL b2b_spacing%0d: got accept %0d resp %0d->%0d expected accept %0d spacing 3",
                 j, acc_cyc[j+1], rsp_cyc[j], rsp_cyc[j+1], rsp_cyc[j] + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_store_half();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule
